// File: rtl/axil_master_seq_if.sv
// AXI4-Lite bus bundle between the command sequencer (master) and a register bank (slave).
interface axil_master_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_master_seq.sv
// AXI4-Lite master sequencer: buffers register read/write commands in a small FIFO and runs
// them strictly in order, one bus transaction at a time, returning one response per command.
module axil_master_seq #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 32,
    parameter int          STRB_W    = DATA_W / 8,
    parameter int          CMD_DEPTH = 4,
    parameter int          TIMEOUT   = 256,
    parameter int          CNT_W     = 16,
    parameter logic [2:0]  PROT      = 3'b000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [STRB_W-1:0] cmd_wstrb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_we_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [1:0]        rsp_resp_o,
    axil_master_seq_if.master axi,
    output logic [CNT_W-1:0]  wr_count_o,
    output logic [CNT_W-1:0]  rd_count_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic              err_timeout_o
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_OUT} state_t;

    // ---------------- command FIFO ----------------
    cmd_t             mem_q [CMD_DEPTH];
    cmd_t             cmd_in, head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             cmd_ready_q;
    logic             push, pop;
    state_t           state_q, state_d;

    assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};
    assign head   = mem_q[rd_ptr_q];
    assign push   = cmd_valid_i && cmd_ready_q;
    assign pop    = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            cmd_ready_q <= (count_d != (PTR_W+1)'(CMD_DEPTH));
        end
    end

    // NOTE: FIFO storage has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    // ---------------- transaction FSM ----------------
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_tmo_q, err_tmo_d;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        err_cnt_d  = err_cnt_q;
        tmo_d      = tmo_q;
        err_tmo_d  = err_tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    we_d      = head.we;
                    addr_d    = head.addr;
                    wdata_d   = head.wdata;
                    wstrb_d   = head.wstrb;
                    awvalid_d = head.we;
                    wvalid_d  = head.we;
                    arvalid_d = !head.we;
                    tmo_d     = '0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                // AW and W retire independently; the phase ends once both have handshaken.
                if (we_q) begin
                    awvalid_d = awvalid_q && !axi.awready;
                    wvalid_d  = wvalid_q && !axi.wready;
                    if (!awvalid_d && !wvalid_d) state_d = S_RESP;
                end else begin
                    arvalid_d = arvalid_q && !axi.arready;
                    if (!arvalid_d) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (we_q && axi.bvalid) begin
                    rsp_data_d = '0;
                    rsp_resp_d = axi.bresp;
                    wr_cnt_d   = wr_cnt_q + CNT_W'(1);
                    if (axi.bresp != 2'b00) err_cnt_d = err_cnt_q + CNT_W'(1);
                    state_d    = S_OUT;
                end else if (!we_q && axi.rvalid) begin
                    rsp_data_d = axi.rdata;
                    rsp_resp_d = axi.rresp;
                    rd_cnt_d   = rd_cnt_q + CNT_W'(1);
                    if (axi.rresp != 2'b00) err_cnt_d = err_cnt_q + CNT_W'(1);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog only flags a slow slave; the transaction keeps running to stay protocol-legal.
        if (TIMEOUT != 0 && (state_q == S_ADDR || state_q == S_RESP)) begin
            if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == TMO_W'(TIMEOUT)) err_tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rsp_data_q <= '0;
            rsp_resp_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            err_cnt_q  <= '0;
            tmo_q      <= '0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            err_cnt_q  <= err_cnt_d;
            tmo_q      <= tmo_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = (state_q == S_OUT);
    assign rsp_we_o      = we_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_resp_o    = rsp_resp_q;
    assign wr_count_o    = wr_cnt_q;
    assign rd_count_o    = rd_cnt_q;
    assign err_count_o   = err_cnt_q;
    assign err_timeout_o = err_tmo_q;

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = PROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = (state_q == S_RESP) && we_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = PROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = (state_q == S_RESP) && !we_q;
endmodule

// File: tb/tb_axil_master_seq.sv
// Directed bench for axil_master_seq: behavioural AXI4-Lite slave, response scoreboard and monitor.
module tb_axil_master_seq;
    localparam int ADDR_W = 8, DATA_W = 32, STRB_W = 4, CMD_DEPTH = 4, TIMEOUT = 8, CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid, cmd_ready, cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid, rsp_ready, rsp_we;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic [CNT_W-1:0]  wr_count, rd_count, err_count;
    logic              err_timeout;

    axil_master_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axil_master_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .CMD_DEPTH(CMD_DEPTH),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .PROT(3'b000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
        .rsp_data_o(rsp_data), .rsp_resp_o(rsp_resp),
        .axi(axi),
        .wr_count_o(wr_count), .rd_count_o(rd_count), .err_count_o(err_count),
        .err_timeout_o(err_timeout)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t exp_q[$];
    time  start_q[$];
    int   n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural slave ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    bit          hold_resp = 0;
    logic [31:0] slv_mem [64];
    int          aw_beats = 0, w_beats = 0, b_beats = 0;

    initial begin : slave
        int   aw_wait, w_wait, ar_wait;
        bit   aw_got, w_got, ar_got, b_done, r_done, prev_any;
        bit   pend_aw, pend_w, pend_ar, hs_aw, hs_w, hs_ar;
        logic [7:0]  aw_addr, ar_addr;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        for (int i = 0; i < 64; i++) slv_mem[i] = '0;
        {aw_wait, w_wait, ar_wait} = '0;
        {aw_got, w_got, ar_got, prev_any, pend_aw, pend_w, pend_ar, hs_aw, hs_w, hs_ar} = '0;
        {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
        axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = '0;
        forever begin
            @(negedge clk);
            b_done = 0; r_done = 0;
            if (rst_n) begin
                // Valids must hold until their handshake and drop right after it.
                if (pend_aw) check("awvalid_hold", axi.awvalid, 1);
                if (pend_w)  check("wvalid_hold", axi.wvalid, 1);
                if (pend_ar) check("arvalid_hold", axi.arvalid, 1);
                if (hs_aw)   check("awvalid_drop", axi.awvalid, 0);
                if (hs_w)    check("wvalid_drop", axi.wvalid, 0);
                if (hs_ar)   check("arvalid_drop", axi.arvalid, 0);
                pend_aw = axi.awvalid && !axi.awready; hs_aw = axi.awvalid && axi.awready;
                pend_w  = axi.wvalid && !axi.wready;   hs_w  = axi.wvalid && axi.wready;
                pend_ar = axi.arvalid && !axi.arready; hs_ar = axi.arvalid && axi.arready;
                if (hs_aw) begin aw_got = 1; aw_addr = axi.awaddr; aw_beats++; end
                if (hs_w)  begin w_got = 1; w_data = axi.wdata; w_strb = axi.wstrb; w_beats++; end
                if (hs_ar) begin ar_got = 1; ar_addr = axi.araddr; end
                b_done = axi.bvalid && axi.bready;
                r_done = axi.rvalid && axi.rready;
                if (b_done) b_beats++;
                if ((axi.awvalid || axi.wvalid || axi.arvalid) && !prev_any) start_q.push_back($time);
                prev_any = axi.awvalid || axi.wvalid || axi.arvalid;
            end else begin
                {pend_aw, pend_w, pend_ar, hs_aw, hs_w, hs_ar, prev_any} = '0;
            end
            @(posedge clk); #1;
            if (!rst_n) begin
                {aw_wait, w_wait, ar_wait} = '0;
                {aw_got, w_got, ar_got} = '0;
                {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
                continue;
            end
            if (b_done) axi.bvalid = 1'b0;
            if (r_done) axi.rvalid = 1'b0;
            aw_wait = axi.awvalid ? aw_wait + 1 : 0;
            w_wait  = axi.wvalid  ? w_wait + 1  : 0;
            ar_wait = axi.arvalid ? ar_wait + 1 : 0;
            axi.awready = axi.awvalid && (aw_wait > aw_delay);
            axi.wready  = axi.wvalid  && (w_wait > w_delay);
            axi.arready = axi.arvalid && (ar_wait > ar_delay);
            if (aw_got && w_got && !axi.bvalid && !hold_resp) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb[b]) slv_mem[aw_addr[7:2]][8*b +: 8] = w_data[8*b +: 8];
                axi.bvalid = 1'b1; axi.bresp = b_resp_cfg;
                aw_got = 0; w_got = 0;
            end
            if (ar_got && !axi.rvalid && !hold_resp) begin
                axi.rdata = slv_mem[ar_addr[7:2]]; axi.rresp = r_resp_cfg; axi.rvalid = 1'b1;
                ar_got = 0;
            end
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rsp_unexpected: got we=%0d data=0x%0h resp=%0d, expected none",
                         rsp_we, rsp_data, rsp_resp);
            end else begin
                e = rsp_ready ? exp_q.pop_front() : exp_q[0];
                check(rsp_ready ? "rsp_we" : "rsp_we_held", rsp_we, e.we);
                check(rsp_ready ? "rsp_data" : "rsp_data_held", rsp_data, e.data);
                check(rsp_ready ? "rsp_resp" : "rsp_resp_held", rsp_resp, e.resp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] edata, input logic [1:0] eresp,
                        input bit track);
        int   waited = 0;
        rsp_t e;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        @(negedge clk);
        while (!cmd_ready && waited < 300) begin @(negedge clk); waited++; end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_accept: got cmd_ready=0 for %0d cycles, expected acceptance", waited);
        end else if (track) begin
            e.we = we; e.data = we ? 32'h0 : edata; e.resp = eresp;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input int wr, input int rd, input int er);
        check({tag, "_wr_count"}, wr_count, wr);
        check({tag, "_rd_count"}, rd_count, rd);
        check({tag, "_err_count"}, err_count, er);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin : stim
        int t;
        int ab, wb, bb;
        cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_err_timeout", err_timeout, 0);
        check_counts("rst", 0, 0, 0);

        // 1: zero-wait write then readback, 4-cycle command spacing
        start_q.delete();
        push(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1);
        push(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1);
        wait_drain();
        check("t1_starts", start_q.size(), 2);
        if (start_q.size() == 2) check("t1_spacing", 64'(start_q[1] - start_q[0]), 64'd40);
        check("t1_aw_beats", aw_beats, 1);
        check("t1_w_beats", w_beats, 1);
        check("t1_b_beats", b_beats, 1);
        check_counts("t1", 1, 1, 0);

        // 2: W accepted three cycles before AW
        aw_delay = 3; ab = aw_beats; wb = w_beats; bb = b_beats;
        fork
            push(1'b1, 8'h30, 32'h1234_5678, 4'hF, 32'h0, 2'b00, 1);
            begin
                t = 0;
                @(negedge clk);
                while (!axi.awvalid && t < 50) begin @(negedge clk); t++; end
                check("t2_aw_start", axi.awvalid, 1);
                @(negedge clk);
                check("t2_wvalid_dropped", axi.wvalid, 0);
                check("t2_awvalid_held", axi.awvalid, 1);
            end
        join
        wait_drain();
        aw_delay = 0;
        check("t2_aw_beats", aw_beats - ab, 1);
        check("t2_w_beats", w_beats - wb, 1);
        check("t2_b_beats", b_beats - bb, 1);
        check_counts("t2", 2, 1, 0);

        // 3: fill FIFO behind a stalled response, ordering and readback
        rsp_ready = 1'b0;
        push(1'b1, 8'h40, 32'h1111_1111, 4'hF, 32'h0, 2'b00, 1);
        push(1'b1, 8'h44, 32'hAABB_CCDD, 4'h3, 32'h0, 2'b00, 1);
        push(1'b0, 8'h40, 32'h0, 4'h0, 32'h1111_1111, 2'b00, 1);
        push(1'b0, 8'h44, 32'h0, 4'h0, 32'h0000_CCDD, 2'b00, 1);
        push(1'b1, 8'h40, 32'h5566_7788, 4'hC, 32'h0, 2'b00, 1);
        fork
            push(1'b0, 8'h40, 32'h0, 4'h0, 32'h5566_1111, 2'b00, 1);
            begin
                repeat (3) @(negedge clk);
                check("t3_cmd_ready_full", cmd_ready, 0);
                @(posedge clk); #1 rsp_ready = 1'b1;
            end
        join
        wait_drain();
        check_counts("t3", 5, 4, 0);

        // 4: read returns SLVERR
        r_resp_cfg = 2'b10;
        push(1'b0, 8'h20, 32'h0, 4'h0, 32'h0, 2'b10, 1);
        wait_drain();
        r_resp_cfg = 2'b00;
        check_counts("t4", 5, 5, 1);
        check("t4_err_timeout", err_timeout, 0);

        // 5: arready withheld 20 cycles against TIMEOUT=8
        ar_delay = 20;
        fork
            push(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 1);
            begin
                t = 0;
                @(negedge clk);
                while (!axi.arvalid && t < 50) begin @(negedge clk); t++; end
                check("t5_ar_start", axi.arvalid, 1);
                repeat (7) @(negedge clk);
                check("t5_no_timeout_yet", err_timeout, 0);
                @(negedge clk);
                check("t5_timeout_set", err_timeout, 1);
                check("t5_arvalid_held", axi.arvalid, 1);
            end
        join
        wait_drain();
        ar_delay = 0;
        check("t5_timeout_sticky", err_timeout, 1);
        check_counts("t5", 5, 6, 1);

        // 6: asynchronous reset while waiting in RESP
        hold_resp = 1; rsp_ready = 1'b0;
        push(1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 2'b00, 0);
        t = 0;
        while (!axi.rready && t < 50) begin @(negedge clk); t++; end
        check("t6_in_resp", axi.rready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_awvalid", axi.awvalid, 0);
        check("t6_wvalid", axi.wvalid, 0);
        check("t6_arvalid", axi.arvalid, 0);
        check("t6_bready", axi.bready, 0);
        check("t6_rready", axi.rready, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_araddr", axi.araddr, 0);
        check("t6_err_timeout", err_timeout, 0);
        check_counts("t6_rst", 0, 0, 0);
        exp_q.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        hold_resp = 0; rsp_ready = 1'b1;
        @(negedge clk);
        check("t6_cmd_ready", cmd_ready, 1);
        repeat (3) @(negedge clk);
        check("t6_fifo_empty", axi.arvalid, 0);
        push(1'b0, 8'h40, 32'h0, 4'h0, 32'h5566_1111, 2'b00, 1);
        wait_drain();
        check_counts("t6_post", 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
